// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared constants for the MiniMIPS32 instruction-fetch stage: reset PC,
// exception codes, bus widths, stall levels and the fetch FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

   localparam int unsigned INST_ADDR_BUS = 32;
   localparam int unsigned WORD_BUS      = 32;
   localparam int unsigned EXC_CODE_BUS  = 5;
   localparam int unsigned STALL_BUS     = 4;

   localparam logic [INST_ADDR_BUS-1:0] PC_INIT   = 32'hBFC0_0000;
   localparam logic [WORD_BUS-1:0]      ZERO_WORD = 32'h0000_0000;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   localparam logic [EXC_CODE_BUS-1:0] EXC_NONE = 5'h10;
   localparam logic [EXC_CODE_BUS-1:0] EXC_ADEL = 5'h04;

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StHold  = 2'd1,
      StDrain = 2'd2
   } fetch_state_e;

   // Word fetches need a 4-byte aligned address.
   function automatic logic is_misaligned(input logic [INST_ADDR_BUS-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_fetch_stage_pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC priority mux: exception flush beats branch/jump,
// which beats the sequential pc+4.
// Ports:
//   flush        in   exception redirect request
//   cp0_excaddr  in   exception handler address
//   jump_flag    in   branch/jump redirect request
//   jump_addr    in   branch/jump target
//   pc           in   current PC
//   pc_next      out  selected next PC
// -----------------------------------------------------------------------------
module pc_next_sel
   import if_fetch_stage_pkg::*;
(
   input  logic                     flush,
   input  logic [INST_ADDR_BUS-1:0] cp0_excaddr,
   input  logic                     jump_flag,
   input  logic [INST_ADDR_BUS-1:0] jump_addr,
   input  logic [INST_ADDR_BUS-1:0] pc,
   output logic [INST_ADDR_BUS-1:0] pc_next
);

   always_comb begin
      pc_next = pc + 32'd4;
      if (flush) begin
         pc_next = cp0_excaddr;
      end else if (jump_flag) begin
         pc_next = jump_addr;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// MiniMIPS32 instruction-fetch stage. Owns the PC, runs a req/ack handshake
// with instruction memory and presents one instruction per accepted cycle to
// the IF/ID register, tagged with PC, PC+4, delay-slot flag and fetch
// exception information.
// Ports:
//   cpu_clk_50M   in   clock, rising edge
//   cpu_rst_n     in   asynchronous active-low reset
//   stall         in   pipeline stall vector, stall[0] freezes IF
//   flush         in   exception flush, redirect to cp0_excaddr
//   cp0_excaddr   in   exception handler PC
//   jump_flag     in   taken branch/jump resolved in ID
//   jump_addr     in   branch/jump target
//   next_delay    in   instruction now in IF is a delay slot
//   iaddr         out  fetch address
//   ireq          out  fetch request
//   iack          in   memory accept / data valid
//   irdata        in   instruction word (valid with iack)
//   if_pc         out  PC of presented instruction
//   if_pc_plus_4  out  PC + 4
//   if_inst       out  presented instruction, 0 when none
//   if_delay      out  presented instruction is a delay slot
//   if_exccode    out  fetch exception code
//   if_badvaddr   out  faulting PC on address error
//   stallreq_if   out  fetch outstanding, stall the pipeline
// -----------------------------------------------------------------------------
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [INST_ADDR_BUS-1:0] PC_RESET = PC_INIT
) (
   input  logic                     cpu_clk_50M,
   input  logic                     cpu_rst_n,
   input  logic [STALL_BUS-1:0]     stall,
   input  logic                     flush,
   input  logic [INST_ADDR_BUS-1:0] cp0_excaddr,
   input  logic                     jump_flag,
   input  logic [INST_ADDR_BUS-1:0] jump_addr,
   input  logic                     next_delay,
   output logic [INST_ADDR_BUS-1:0] iaddr,
   output logic                     ireq,
   input  logic                     iack,
   input  logic [WORD_BUS-1:0]      irdata,
   output logic [INST_ADDR_BUS-1:0] if_pc,
   output logic [INST_ADDR_BUS-1:0] if_pc_plus_4,
   output logic [WORD_BUS-1:0]      if_inst,
   output logic                     if_delay,
   output logic [EXC_CODE_BUS-1:0]  if_exccode,
   output logic [INST_ADDR_BUS-1:0] if_badvaddr,
   output logic                     stallreq_if
);

   fetch_state_e state_q, state_d;

   logic [INST_ADDR_BUS-1:0] pc_q, pc_d;
   logic [WORD_BUS-1:0]      hold_q, hold_d;
   logic [INST_ADDR_BUS-1:0] pend_q, pend_d;
   logic                     pend_flush_q, pend_flush_d;
   logic                     delay_q, delay_d;

   logic                     in_fetch, in_hold, in_drain;
   logic                     misaligned, stalled;
   logic                     req, outstanding, avail, valid, accept;
   logic                     jump_eff;
   logic [INST_ADDR_BUS-1:0] redirect_pc, drain_pc;

   // Only stall[0] concerns this stage.
   logic unused_stall;
   assign unused_stall = ^stall[STALL_BUS-1:1];

   assign in_fetch   = (state_q == StFetch);
   assign in_hold    = (state_q == StHold);
   assign in_drain   = (state_q == StDrain);
   assign misaligned = is_misaligned(pc_q);
   assign stalled    = (stall[0] == STOP);

   // Gating with the reset pin drops ireq the moment reset asserts.
   assign req         = in_fetch & ~misaligned & cpu_rst_n;
   assign outstanding = req & ~iack;
   assign avail       = in_fetch & (misaligned | (req & iack));
   assign valid       = (avail | in_hold) & cpu_rst_n;
   assign accept      = valid & ~stalled;

   // A jump seen while the stage is frozen with an instruction in hand is left
   // for ID to re-present; while memory is busy it must be captured now.
   assign jump_eff = jump_flag & (~stalled | outstanding | in_drain);

   pc_next_sel u_pc_next_sel (
      .flush       (flush),
      .cp0_excaddr (cp0_excaddr),
      .jump_flag   (jump_eff),
      .jump_addr   (jump_addr),
      .pc          (pc_q),
      .pc_next     (redirect_pc)
   );

   // While draining, a new flush always wins; a jump may only replace a
   // jump target, never a pending exception target.
   always_comb begin
      drain_pc = pend_q;
      if (flush) begin
         drain_pc = cp0_excaddr;
      end else if (jump_flag && !pend_flush_q) begin
         drain_pc = jump_addr;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_d       = hold_q;
      pend_d       = pend_q;
      pend_flush_d = pend_flush_q;
      delay_d      = delay_q;

      if (req && iack) begin
         hold_d = irdata;
      end

      unique case (state_q)
         StFetch: begin
            if (outstanding) begin
               // Memory cannot cancel: park the target until the ack arrives.
               if (flush || jump_eff) begin
                  state_d      = StDrain;
                  pend_d       = redirect_pc;
                  pend_flush_d = flush;
               end
            end else if (avail) begin
               if (flush || !stalled) begin
                  pc_d = redirect_pc;
               end else begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (flush || !stalled) begin
               pc_d    = redirect_pc;
               state_d = StFetch;
            end
         end
         StDrain: begin
            if (iack) begin
               pc_d         = drain_pc;
               pend_flush_d = 1'b0;
               state_d      = StFetch;
            end else begin
               pend_d       = drain_pc;
               pend_flush_d = pend_flush_q | flush;
            end
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      if (flush) begin
         delay_d = 1'b0;
      end else if (accept) begin
         delay_d = next_delay;
      end
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q      <= StFetch;
         pc_q         <= PC_RESET;
         hold_q       <= ZERO_WORD;
         pend_q       <= ZERO_WORD;
         pend_flush_q <= 1'b0;
         delay_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_q       <= hold_d;
         pend_q       <= pend_d;
         pend_flush_q <= pend_flush_d;
         delay_q      <= delay_d;
      end
   end

   always_comb begin
      ireq         = req;
      iaddr        = pc_q;
      if_pc        = pc_q;
      if_pc_plus_4 = pc_q + 32'd4;
      if_inst      = ZERO_WORD;
      if_exccode   = EXC_NONE;
      if_badvaddr  = ZERO_WORD;
      if_delay     = valid & delay_q;
      stallreq_if  = outstanding | in_drain;

      if (valid) begin
         if (misaligned) begin
            if_exccode  = EXC_ADEL;
            if_badvaddr = pc_q;
         end else if (in_hold) begin
            if_inst = hold_q;
         end else begin
            if_inst = irdata;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
   import if_fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  stall;
   logic        flush;
   logic [31:0] cp0_excaddr;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        next_delay;
   logic [31:0] iaddr;
   logic        ireq;
   logic        iack;
   logic [31:0] irdata;
   logic [31:0] if_pc, if_pc_plus_4, if_inst, if_badvaddr;
   logic        if_delay;
   logic [4:0]  if_exccode;
   logic        stallreq_if;

   always #5 clk = ~clk;

   if_fetch_stage #(.PC_RESET(32'hBFC0_0000)) dut (
      .cpu_clk_50M  (clk),
      .cpu_rst_n    (rst_n),
      .stall        (stall),
      .flush        (flush),
      .cp0_excaddr  (cp0_excaddr),
      .jump_flag    (jump_flag),
      .jump_addr    (jump_addr),
      .next_delay   (next_delay),
      .iaddr        (iaddr),
      .ireq         (ireq),
      .iack         (iack),
      .irdata       (irdata),
      .if_pc        (if_pc),
      .if_pc_plus_4 (if_pc_plus_4),
      .if_inst      (if_inst),
      .if_delay     (if_delay),
      .if_exccode   (if_exccode),
      .if_badvaddr  (if_badvaddr),
      .stallreq_if  (stallreq_if)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        s0;
      logic        fl;
      logic [31:0] exc;
      logic        jf;
      logic [31:0] ja;
      logic        nd;
      logic        ack;
      logic [31:0] rd;
      logic        e_ireq;
      logic [31:0] e_iaddr;
      logic [31:0] e_inst;
      logic        e_sr;
      logic        e_dly;
      logic [4:0]  e_exc;
      logic [31:0] e_bad;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s0, logic fl, logic [31:0] exc, logic jf, logic [31:0] ja,
                               logic nd, logic ack, logic [31:0] rd, logic e_ireq,
                               logic [31:0] e_iaddr, logic [31:0] e_inst, logic e_sr,
                               logic e_dly, logic [4:0] e_exc, logic [31:0] e_bad);
      vec_t v;
      v.s0 = s0; v.fl = fl; v.exc = exc; v.jf = jf; v.ja = ja; v.nd = nd;
      v.ack = ack; v.rd = rd; v.e_ireq = e_ireq; v.e_iaddr = e_iaddr;
      v.e_inst = e_inst; v.e_sr = e_sr; v.e_dly = e_dly; v.e_exc = e_exc; v.e_bad = e_bad;
      return v;
   endfunction

   task automatic build_vectors();
      // zero-wait fetches
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h2408_0001, 1,32'hBFC0_0000,32'h2408_0001,0,0,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h2409_0002, 1,32'hBFC0_0004,32'h2409_0002,0,0,5'h10,0));
      // two wait cycles then ack
      vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,         1,32'hBFC0_0008,32'h0,1,0,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,         1,32'hBFC0_0008,32'h0,1,0,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h3C01_1234, 1,32'hBFC0_0008,32'h3C01_1234,0,0,5'h10,0));
      // stall during ack cycle, held for 3 cycles, then release
      vecs.push_back(mk(1,0,0,0,0,0,1,32'hAAAA_0001, 1,32'hBFC0_000C,32'hAAAA_0001,0,0,5'h10,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,32'h0,         0,32'h0,32'hAAAA_0001,0,0,5'h10,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,32'h0,         0,32'h0,32'hAAAA_0001,0,0,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,32'h0,32'hAAAA_0001,0,0,5'h10,0));
      // branch accepted with next_delay, delay slot with jump, then target
      vecs.push_back(mk(0,0,0,0,0,1,1,32'h1000_0040, 1,32'hBFC0_0010,32'h1000_0040,0,0,5'h10,0));
      vecs.push_back(mk(0,0,0,1,32'hBFC0_0100,0,1,32'h2402_0005,
                        1,32'hBFC0_0014,32'h2402_0005,0,1,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h2403_0006, 1,32'hBFC0_0100,32'h2403_0006,0,0,5'h10,0));
      // flush with fetch outstanding -> drain, late data discarded
      vecs.push_back(mk(0,1,32'hBFC0_0380,0,0,0,0,0, 1,32'hBFC0_0104,32'h0,1,0,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,32'h0,32'h0,1,0,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'hDEAD_BEEF, 0,32'h0,32'h0,1,0,5'h10,0));
      // handler fetch, with jump to a misaligned target
      vecs.push_back(mk(0,0,0,1,32'hBFC0_0102,0,1,32'h4080_6000,
                        1,32'hBFC0_0380,32'h4080_6000,0,0,5'h10,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,32'h0,         0,32'h0,32'h0,0,0,5'h04,32'hBFC0_0102));
      vecs.push_back(mk(0,0,0,1,32'hBFC0_0200,0,0,0, 0,32'h0,32'h0,0,0,5'h04,32'hBFC0_0106));
      vecs.push_back(mk(0,0,0,0,0,0,1,32'h1234_5678, 1,32'hBFC0_0200,32'h1234_5678,0,0,5'h10,0));
   endtask

   task automatic idle_inputs();
      stall = 4'b0; flush = 0; cp0_excaddr = 0; jump_flag = 0; jump_addr = 0;
      next_delay = 0; iack = 0; irdata = 0;
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_held;
   logic [31:0] m_tgt;
   bit          m_hold;   // instruction in hand, waiting for stall release
   bit          m_drain;  // discarding a response after a redirect
   bit          m_tflush; // pending target came from an exception
   bit          m_delay;

   task automatic model_reset();
      m_pc = 32'hBFC0_0000; m_held = 0; m_tgt = 0;
      m_hold = 0; m_drain = 0; m_tflush = 0; m_delay = 0;
   endtask

   function automatic bit m_requesting();
      return !m_drain && !m_hold && (m_pc[1:0] == 2'b00);
   endfunction

   task automatic model_compare(input int cyc);
      bit mis, e_ireq, avail, valid;
      string t;
      t = $sformatf("rand%0d", cyc);
      mis    = (m_pc[1:0] != 2'b00);
      e_ireq = m_requesting();
      avail  = !m_drain && !m_hold && (mis || (e_ireq && iack));
      valid  = avail || m_hold;
      chk({t, " ireq"}, 32'(ireq), 32'(e_ireq));
      if (e_ireq) chk({t, " iaddr"}, iaddr, m_pc);
      chk({t, " inst"}, if_inst, (!valid || mis) ? 32'h0 : (m_hold ? m_held : irdata));
      chk({t, " exccode"}, 32'(if_exccode), (valid && mis) ? 32'h04 : 32'h10);
      chk({t, " badvaddr"}, if_badvaddr, (valid && mis) ? m_pc : 32'h0);
      chk({t, " delay"}, 32'(if_delay), 32'(valid && m_delay));
      chk({t, " stallreq"}, 32'(stallreq_if), 32'((e_ireq && !iack) || m_drain));
      if (valid) begin
         chk({t, " if_pc"}, if_pc, m_pc);
         chk({t, " if_pc4"}, if_pc_plus_4, m_pc + 32'd4);
      end
   endtask

   task automatic model_step();
      bit mis, e_ireq, avail, valid, outst, jok, s0;
      s0     = stall[0];
      mis    = (m_pc[1:0] != 2'b00);
      e_ireq = m_requesting();
      avail  = !m_drain && !m_hold && (mis || (e_ireq && iack));
      valid  = avail || m_hold;
      outst  = e_ireq && !iack;
      jok    = jump_flag && (!s0 || outst || m_drain);
      if (e_ireq && iack) m_held = irdata;
      if (flush) m_delay = 0;
      else if (valid && !s0) m_delay = next_delay;
      if (m_drain) begin
         if (flush) begin
            m_tgt = cp0_excaddr; m_tflush = 1;
         end else if (jump_flag && !m_tflush) begin
            m_tgt = jump_addr;
         end
         if (iack) begin
            m_pc = m_tgt; m_drain = 0; m_tflush = 0;
         end
      end else if (outst) begin
         if (flush || jok) begin
            m_drain = 1; m_tgt = flush ? cp0_excaddr : jump_addr; m_tflush = flush;
         end
      end else if (valid) begin
         if (flush) begin
            m_pc = cp0_excaddr; m_hold = 0;
         end else if (!s0) begin
            m_pc = jok ? jump_addr : m_pc + 32'd4; m_hold = 0;
         end else begin
            m_hold = 1;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      idle_inputs();
      rst_n = 0;
      build_vectors();
      #12;
      chk("reset ireq", 32'(ireq), 32'h0);
      chk("reset inst", if_inst, 32'h0);
      chk("reset exccode", 32'(if_exccode), 32'h10);
      chk("reset badvaddr", if_badvaddr, 32'h0);
      chk("reset delay", 32'(if_delay), 32'h0);
      chk("reset stallreq", 32'(stallreq_if), 32'h0);
      @(negedge clk);
      rst_n = 1;

      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         stall = {3'b000, vecs[i].s0};
         flush = vecs[i].fl; cp0_excaddr = vecs[i].exc;
         jump_flag = vecs[i].jf; jump_addr = vecs[i].ja; next_delay = vecs[i].nd;
         iack = vecs[i].ack; irdata = vecs[i].rd;
         #1;
         chk($sformatf("vec%0d ireq", i), 32'(ireq), 32'(vecs[i].e_ireq));
         if (vecs[i].e_ireq) chk($sformatf("vec%0d iaddr", i), iaddr, vecs[i].e_iaddr);
         chk($sformatf("vec%0d inst", i), if_inst, vecs[i].e_inst);
         chk($sformatf("vec%0d stallreq", i), 32'(stallreq_if), 32'(vecs[i].e_sr));
         chk($sformatf("vec%0d delay", i), 32'(if_delay), 32'(vecs[i].e_dly));
         chk($sformatf("vec%0d exccode", i), 32'(if_exccode), 32'(vecs[i].e_exc));
         chk($sformatf("vec%0d badvaddr", i), if_badvaddr, vecs[i].e_bad);
      end

      // reset asserted mid-fetch: ireq must drop without waiting for a clock
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      chk("pre-midreset ireq", 32'(ireq), 32'h1);
      chk("pre-midreset iaddr", iaddr, 32'hBFC0_0000);
      #1 rst_n = 0;
      #1;
      chk("midreset ireq", 32'(ireq), 32'h0);
      chk("midreset stallreq", 32'(stallreq_if), 32'h0);
      @(negedge clk);
      rst_n = 1;
      model_reset();

      for (int c = 0; c < 3000; c++) begin
         if (c != 0) @(negedge clk);
         stall[3:1]  = 3'($urandom_range(0, 7));
         stall[0]    = ($urandom_range(0, 99) < 25);
         flush       = ($urandom_range(0, 99) < 4);
         cp0_excaddr = 32'hBFC0_0000 | (32'($urandom_range(0, 255)) << 2);
         jump_flag   = ($urandom_range(0, 99) < 12);
         jump_addr   = 32'hBFC0_0000 | (32'($urandom_range(0, 1023)) << 2)
                       | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
         next_delay  = ($urandom_range(0, 99) < 30);
         iack        = (m_requesting() || m_drain) && ($urandom_range(0, 99) < 60);
         irdata      = $urandom;
         #1;
         model_compare(c);
         model_step();
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
